audio_capture: RTL
==================

AUDIO_CAPTURE -- requirements
Module: audio_capture

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning log2 of samples per channel (DEPTH = 2**ADDR_W).
REQ-002 The block SHALL have parameter SAMPLE_W, default 10, meaning the stored sample width.
REQ-003 The block SHALL have parameter DECIM, default 10000, meaning integration clocks per sample window (DECIM >= 1).
REQ-004 The block SHALL have parameter SETTLE, default 0, meaning discarded clocks at the start of each window, after a mic_lr_sel change.
REQ-005 The block SHALL have parameter CHANNELS, default 1, meaning channel count; legal values are 1 or 2.
REQ-006 The block SHALL have parameter BITREV, default 1, meaning 1 = bit-reversed index addressing and 0 = linear addressing.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port start, input, 1 bit: capture request, sampled in IDLE.
REQ-010 The block SHALL have port abort, input, 1 bit: cancel the capture in progress.
REQ-011 The block SHALL have port mic_data, input, 1 bit: PDM bit from the microphone.
REQ-012 The block SHALL have port mic_lr_sel, output, 1 bit: microphone channel select, equal to the current channel.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse when a capture completes.
REQ-015 The block SHALL have port we, output, 1 bit: memory write enable.
REQ-016 The block SHALL have port mem_addr, output, AW = ADDR_W + (CHANNELS==2): memory address.
REQ-017 The block SHALL have port mem_data, output, SAMPLE_W bits: memory write data.

Function
REQ-018 The state machine SHALL have exactly four states: IDLE, INTEG, WRITE and DONE.
REQ-019 In IDLE with start=1 and abort=0, the next edge SHALL clear idx, ch, cnt and acc and SHALL enter INTEG.
REQ-020 In INTEG, cnt SHALL increment every clock; while cnt >= SETTLE, acc SHALL add mic_data.
REQ-021 In INTEG, on the clock where cnt = SETTLE+DECIM-1, the block SHALL enter WRITE and register we=1, mem_data and mem_addr.
REQ-022 mem_data SHALL equal min(ones counted in the window, 2**SAMPLE_W-1), unsigned and saturating, with no wrap.
REQ-023 mem_addr SHALL equal {ch, bitrev_ADDR_W(idx)} when BITREV=1 and {ch, idx} when BITREV=0; the ch bit SHALL be absent when CHANNELS=1.
REQ-024 we SHALL be high for exactly one clock per sample, while in WRITE.
REQ-025 A window SHALL occupy SETTLE+DECIM clocks in INTEG plus one WRITE clock.
REQ-026 From WRITE, if CHANNELS=2 and ch=0, the block SHALL set ch=1, clear cnt and acc, and return to INTEG.
REQ-027 From WRITE, otherwise, the block SHALL set ch=0.
REQ-028 From WRITE, if idx = DEPTH-1, the block SHALL enter DONE; else it SHALL increment idx and return to INTEG with cnt and acc cleared.
REQ-029 In DONE, done SHALL be 1 for one clock and the next edge SHALL return to IDLE.
REQ-030 Total capture time, from the start-sampling edge to the done pulse, SHALL be DEPTH*CHANNELS*(SETTLE+DECIM+1)+1 clocks.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 A start that is held high SHALL re-trigger a capture on the cycle after DONE.
REQ-033 abort=1 in any state SHALL force IDLE on the next edge, with we=0 and no done pulse; memory contents already written are left as is.
REQ-034 When start=1 and abort=1 together in IDLE, abort SHALL win and no capture SHALL start.
REQ-035 The accumulator width SHALL be clog2(DECIM+1) and SHALL never overflow.
REQ-036 cnt width SHALL be clog2(SETTLE+DECIM).

Reset
REQ-037 rst_n=0 SHALL asynchronously force state=IDLE and clear idx, ch, cnt and acc.
REQ-038 rst_n=0 SHALL asynchronously force we=0, done=0, busy=0, mic_lr_sel=0, mem_addr=0 and mem_data=0.
REQ-039 Reset asserted mid-capture SHALL abandon the capture with no done pulse.
REQ-040 After reset release, the block SHALL wait in IDLE for start.

Structure
REQ-041 Package audio_pkg SHALL hold the state enum typedef and a function bitrev(value, width).
REQ-042 Sub-module pdm_integrator SHALL hold cnt, acc and the saturation logic, with ports clk, rst_n, clr, mic_data and window_end, and output sample.
REQ-043 All remaining logic, including the FSM and address generation, SHALL stay in audio_capture.

Verification
REQ-044 With ADDR_W=3, DECIM=4, SETTLE=1, CHANNELS=1, BITREV=1 and mic_data=1, a start pulse SHALL produce writes of 4 to addresses 0,4,2,6,1,5,3,7, and done SHALL pulse 49 clocks after the start edge.
REQ-045 With SAMPLE_W=2, DECIM=8 and mic_data=1, every write SHALL carry mem_data=3 (saturated).
REQ-046 With mic_data alternating 1,0, DECIM=4, SETTLE=0 and BITREV=0, mem_data SHALL be 2 and mem_addr SHALL run 0..7 in order.
REQ-047 With CHANNELS=2, ADDR_W=2 and mic_data=mic_lr_sel, the L writes at addresses 0..3 SHALL carry 0, the R writes at addresses 4..7 SHALL carry DECIM, and mic_lr_sel SHALL toggle every window.
REQ-048 An abort at the 3rd WRITE SHALL give exactly 3 writes, no done pulse, busy=0 next clock, and a later start SHALL restart at idx 0.
REQ-049 rst_n pulsed low mid-INTEG SHALL immediately clear all outputs; start together with abort in IDLE SHALL leave busy=0.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and helpers for the PDM audio capture block
// Purpose: capture FSM state encoding and the address bit-reversal helper.
// Contents: state_t (IDLE/INTEG/WRITE/DONE), bitrev(value, width).
package audio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_INTEG = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Reverses the low 'width' bits of value; bits above width come back zero.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < width; i++) begin
         r[i] = value[width-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/pdm_integrator.sv
// rtl/pdm_integrator.sv - PDM ones-counter over one sample window with saturation
// Purpose: counts window clocks, accumulates mic_data after the settle period and
//          presents the saturated count of the window, including the current bit.
// Ports:   clk, rst_n (async, active-low), clr (restart window), mic_data (PDM bit),
//          window_end (last clock of the window), sample (saturated ones count).
module pdm_integrator #(
   parameter int SAMPLE_W = 10,
   parameter int DECIM    = 10000,
   parameter int SETTLE   = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                mic_data,
   output logic                window_end,
   output logic [SAMPLE_W-1:0] sample
);

   localparam int CNT_W = (SETTLE + DECIM > 1) ? $clog2(SETTLE + DECIM) : 1;
   localparam int ACC_W = $clog2(DECIM + 1);
   localparam int EXT_W = ((ACC_W > SAMPLE_W) ? ACC_W : SAMPLE_W) + 1;
   localparam logic [EXT_W-1:0] SAT_MAX = {{(EXT_W-SAMPLE_W){1'b0}}, {SAMPLE_W{1'b1}}};

   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] acc;
   logic [EXT_W-1:0] total;
   logic             gate_bit;
   int               cnt_i;

   // Signed view of cnt keeps the settle comparison meaningful when SETTLE is 0.
   always_comb begin
      cnt_i      = int'(cnt);
      gate_bit   = mic_data && (cnt_i >= SETTLE);
      window_end = (cnt_i == SETTLE + DECIM - 1);
      // The bit arriving on the last window clock belongs to this sample.
      total      = EXT_W'(acc) + EXT_W'(gate_bit);
      sample     = (total > SAT_MAX) ? SAT_MAX[SAMPLE_W-1:0] : total[SAMPLE_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
      end else if (clr) begin
         cnt <= '0;
         acc <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
         acc <= acc + ACC_W'(gate_bit);
      end
   end

endmodule

// File: rtl/audio_capture.sv
// rtl/audio_capture.sv - PDM microphone capture into a sample memory
// Purpose: integrates PDM bits into samples, one window per sample per channel, and
//          writes them to memory with linear or bit-reversed addressing.
// Ports:   clk, rst_n (async, active-low), start, abort, mic_data (PDM in),
//          mic_lr_sel (current channel), busy, done (1-cycle), we, mem_addr, mem_data.
module audio_capture
   import audio_pkg::*;
#(
   parameter int ADDR_W   = 10,
   parameter int SAMPLE_W = 10,
   parameter int DECIM    = 10000,
   parameter int SETTLE   = 0,
   parameter int CHANNELS = 1,
   parameter int BITREV   = 1
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       start,
   input  logic                                       abort,
   input  logic                                       mic_data,
   output logic                                       mic_lr_sel,
   output logic                                       busy,
   output logic                                       done,
   output logic                                       we,
   output logic [ADDR_W+((CHANNELS==2) ? 1 : 0)-1:0] mem_addr,
   output logic [SAMPLE_W-1:0]                        mem_data
);

   localparam int AW = ADDR_W + ((CHANNELS == 2) ? 1 : 0);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx;
   logic                ch;
   logic                window_end;
   logic                integ_clr;
   logic                last_idx;
   logic                stereo_left;
   logic [SAMPLE_W-1:0] sample;
   logic [ADDR_W-1:0]   addr_lo;
   logic [AW-1:0]       addr_next;

   // Integrator idles at zero outside INTEG so every window starts from a clean count.
   assign integ_clr   = (state_q != ST_INTEG) || window_end || abort;
   assign last_idx    = &idx;
   assign stereo_left = (CHANNELS == 2) && !ch;

   pdm_integrator #(
      .SAMPLE_W (SAMPLE_W),
      .DECIM    (DECIM),
      .SETTLE   (SETTLE)
   ) u_integ (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (integ_clr),
      .mic_data   (mic_data),
      .window_end (window_end),
      .sample     (sample)
   );

   always_comb begin
      addr_lo = idx;
      if (BITREV != 0) begin
         addr_lo = ADDR_W'(bitrev(32'(idx), ADDR_W));
      end
   end

   generate
      if (CHANNELS == 2) begin : g_stereo
         assign addr_next = {ch, addr_lo};
      end else begin : g_mono
         assign addr_next = addr_lo;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_INTEG;
         ST_INTEG: if (window_end) state_d = ST_WRITE;
         ST_WRITE: begin
            if (stereo_left || !last_idx) state_d = ST_INTEG;
            else                          state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // Abort overrides everything, including a start seen in IDLE.
      if (abort) state_d = ST_IDLE;
   end

   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign mic_lr_sel = ch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         ch       <= 1'b0;
         we       <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else begin
         we <= 1'b0;
         if (abort) begin
            ch <= 1'b0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     idx <= '0;
                     ch  <= 1'b0;
                  end
               end
               ST_INTEG: begin
                  if (window_end) begin
                     we       <= 1'b1;
                     mem_data <= sample;
                     mem_addr <= addr_next;
                  end
               end
               ST_WRITE: begin
                  if (stereo_left) begin
                     ch <= 1'b1;
                  end else begin
                     ch <= 1'b0;
                     if (!last_idx) idx <= idx + ADDR_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
